// File: rtl/joystick_conditioner.sv
// Joystick conditioner: 2-flop sync, per-channel debounce, up/down arbitration FSM.
// Optional LAST_PRESS_PRIORITY_EN: when both directions are held, the most recent press wins.
module joystick_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_up_n,
    input  logic btn_down_n,
    output logic control_up,
    output logic control_down,
    output logic up_db,
    output logic down_db,
    output logic up_press,
    output logic down_press
);

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned CH_UP  = 0;
    localparam int unsigned CH_DN  = 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 1);

    // State encoding is {control_up, control_down} so controls come straight off flops.
    localparam logic [1:0] NEUTRAL = 2'b11;
    localparam logic [1:0] UP      = 2'b01;
    localparam logic [1:0] DOWN    = 2'b10;

    logic [NUM_CH-1:0] btn_n;
    logic [NUM_CH-1:0] s1;
    logic [NUM_CH-1:0] s2;
    logic [NUM_CH-1:0] stable;
    logic [CNT_W-1:0]  cnt [NUM_CH];

    logic       up_db_q;
    logic       down_db_q;
    logic       up_rise;
    logic       down_rise;
    logic [1:0] state;
    logic [1:0] state_next;

    assign btn_n = {btn_down_n, btn_up_n};

    // Synchronizer and debounce counters; stable holds the active-low settled level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1     <= '1;
            s2     <= '1;
            stable <= '1;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= btn_n;
            s2 <= s1;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == TERMINAL) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign up_db     = ~stable[CH_UP];
    assign down_db   = ~stable[CH_DN];
    assign up_rise   = up_db & ~up_db_q;
    assign down_rise = down_db & ~down_db_q;

    // Press pulses fire on the edge after the debounced level rises.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            up_db_q    <= 1'b0;
            down_db_q  <= 1'b0;
            up_press   <= 1'b0;
            down_press <= 1'b0;
        end else begin
            up_db_q    <= up_db;
            down_db_q  <= down_db;
            up_press   <= up_rise;
            down_press <= down_rise;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= NEUTRAL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
`ifdef LAST_PRESS_PRIORITY_EN
            NEUTRAL: begin
                if (up_db && !down_db) begin
                    state_next = UP;
                end else if (down_db && !up_db) begin
                    state_next = DOWN;
                end else if (up_db && down_db && up_rise && !down_rise) begin
                    state_next = UP;
                end else if (up_db && down_db && down_rise && !up_rise) begin
                    state_next = DOWN;
                end
            end
            UP: begin
                if (down_rise) begin
                    state_next = DOWN;
                end else if (!up_db) begin
                    state_next = down_db ? DOWN : NEUTRAL;
                end
            end
            DOWN: begin
                if (up_rise) begin
                    state_next = UP;
                end else if (!down_db) begin
                    state_next = up_db ? UP : NEUTRAL;
                end
            end
`else
            NEUTRAL: begin
                if (up_db && !down_db) begin
                    state_next = UP;
                end else if (down_db && !up_db) begin
                    state_next = DOWN;
                end
            end
            UP: begin
                if (!up_db || down_db) begin
                    state_next = NEUTRAL;
                end
            end
            DOWN: begin
                if (!down_db || up_db) begin
                    state_next = NEUTRAL;
                end
            end
`endif
            default: state_next = NEUTRAL;
        endcase
    end

    assign control_up   = state[1];
    assign control_down = state[0];

endmodule

// File: tb/tb_joystick_conditioner.sv
// Directed bench for joystick_conditioner (DEBOUNCE_CYCLES=4); per-edge expected
// output vectors {control_up, control_down, up_db, down_db, up_press, down_press}.
module tb_joystick_conditioner;

    localparam int unsigned DB = 4;

`ifdef LAST_PRESS_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    localparam logic [5:0] IDLE = 6'b110000;

    logic clock;
    logic reset;
    logic btn_up_n;
    logic btn_down_n;
    logic control_up;
    logic control_down;
    logic up_db;
    logic down_db;
    logic up_press;
    logic down_press;

    int tests_run;
    int tests_failed;

    logic [5:0] sb_q [$];

    joystick_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (18)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .btn_up_n    (btn_up_n),
        .btn_down_n  (btn_down_n),
        .control_up  (control_up),
        .control_down(control_down),
        .up_db       (up_db),
        .down_db     (down_db),
        .up_press    (up_press),
        .down_press  (down_press)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Drive inputs at the falling edge, expect a vector just after the next rising edge.
    task automatic step(input logic u, input logic d, input logic [5:0] exp, input string tag);
        logic [5:0] obs;
        logic [5:0] want;
        @(negedge clock);
        btn_up_n   = u;
        btn_down_n = d;
        sb_q.push_back(exp);
        @(posedge clock);
        #1;
        obs = {control_up, control_down, up_db, down_db, up_press, down_press};
        tests_run++;
        if (sb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL %s: scoreboard empty, observed=%b", tag, obs);
        end else begin
            want = sb_q.pop_front();
            assert (obs === want) else begin
                tests_failed++;
                $error("FAIL %s: observed=%b expected=%b", tag, obs, want);
            end
        end
    endtask

    task automatic hold(input logic u, input logic d, input logic [5:0] exp, input int n,
                        input string tag);
        for (int k = 0; k < n; k++) begin
            step(u, d, exp, tag);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        btn_up_n     = 1'b1;
        btn_down_n   = 1'b1;

        // Buttons toggling while reset is held must not disturb anything.
        step(1'b0, 1'b1, IDLE, "rst_hold_a");
        step(1'b1, 1'b0, IDLE, "rst_hold_b");
        step(1'b0, 1'b0, IDLE, "rst_hold_c");
        reset = 1'b1;
        hold(1'b1, 1'b1, IDLE, 2, "idle");

        // Start an up press, then reset mid-count.
        hold(1'b0, 1'b1, IDLE, 4, "up_partial");
        reset = 1'b0;
        step(1'b0, 1'b1, IDLE, "rst_mid");
        reset = 1'b1;

        // Held up press after reset needs a full window: db at E5, control/pulse at E6.
        hold(1'b0, 1'b1, IDLE, 5, "up_wait");
        step(1'b0, 1'b1, 6'b111000, "up_db_rise");
        step(1'b0, 1'b1, 6'b011010, "up_ctrl_press");
        step(1'b0, 1'b1, 6'b011000, "up_press_end");

        // Down bounces 0,1,0,1 then settles at 0 while up is held.
        step(1'b0, 1'b0, 6'b011000, "bounce_0");
        step(1'b0, 1'b1, 6'b011000, "bounce_1");
        step(1'b0, 1'b0, 6'b011000, "bounce_2");
        step(1'b0, 1'b1, 6'b011000, "bounce_3");
        hold(1'b0, 1'b0, 6'b011000, 5, "bounce_settle");
        step(1'b0, 1'b0, 6'b011100, "down_db_rise");
        step(1'b0, 1'b0, PRIO ? 6'b101101 : 6'b111101, "both_arb");
        step(1'b0, 1'b0, PRIO ? 6'b101100 : 6'b111100, "both_hold");

        // Release down while up still held.
        hold(1'b0, 1'b1, PRIO ? 6'b101100 : 6'b111100, 5, "down_rel_wait");
        step(1'b0, 1'b1, PRIO ? 6'b101000 : 6'b111000, "down_db_fall");
        step(1'b0, 1'b1, 6'b011000, "back_to_up");

        // Release up after a long hold: no pulse on release.
        hold(1'b1, 1'b1, 6'b011000, 5, "up_rel_wait");
        step(1'b1, 1'b1, 6'b010000, "up_db_fall");
        step(1'b1, 1'b1, IDLE, "up_ctrl_idle");
        step(1'b1, 1'b1, IDLE, "idle_after_up");

        // Both pressed on the same edge from NEUTRAL stays NEUTRAL.
        hold(1'b0, 1'b0, IDLE, 5, "both_wait");
        step(1'b0, 1'b0, 6'b111100, "both_db_rise");
        step(1'b0, 1'b0, 6'b111111, "both_press");
        step(1'b0, 1'b0, 6'b111100, "both_neutral");
        hold(1'b1, 1'b1, 6'b111100, 5, "both_rel_wait");
        step(1'b1, 1'b1, IDLE, "both_db_fall");
        step(1'b1, 1'b1, IDLE, "final_idle");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/joystick_conditioner.md
Name: joystick_conditioner

Overview:
- Sits directly upstream of the paddle controller, one instance per player.
- Takes raw, asynchronous, bouncing active-low joystick/button lines and synchronizes and debounces them.
- Arbitrates up/down conflicts and drives the paddle's active-low control_up/control_down inputs.
- Also exports debounced levels and one-cycle press pulses for game-start/menu logic.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive clock cycles a synchronized input must differ from its stable level before the stable level flips; legal range 2..2^CNT_W-1.
- CNT_W, 18: width of each debounce counter.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset; deasserted synchronously by the system.
- btn_up_n  input  1  raw up switch, active-low, asynchronous to clock, may bounce.
- btn_down_n  input  1  raw down switch, active-low, asynchronous to clock, may bounce.
- control_up  output  1  to paddle; 0 = move up, 1 = idle.
- control_down  output  1  to paddle; 0 = move down, 1 = idle.
- up_db  output  1  debounced up level, active-high (1 = pressed).
- down_db  output  1  debounced down level, active-high (1 = pressed).
- up_press  output  1  one-cycle pulse on debounced up press edge.
- down_press  output  1  one-cycle pulse on debounced down press edge.

Behaviour:
- Reset (reset=0, async):
  - sync flops = 1 (released); stable levels = released; counters = 0.
  - FSM = NEUTRAL.
  - control_up = control_down = 1; up_db = down_db = 0; up_press = down_press = 0.
- Synchronizer: two flops per channel, s1 <= btn_n, s2 <= s1. No logic between the two flops.
- Debounce, per channel, each edge:
  - if s2 == stable: cnt <= 0.
  - else if cnt == DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0.
  - else: cnt <= cnt+1.
  - Any glitch back to the stable level before terminal count restarts the count from 0.
  - Counter never wraps.
- Latency: raw change sampled at edge E0 makes up_db/down_db change after edge E0+DEBOUNCE_CYCLES+1. The FSM and control outputs follow one edge later (E0+DEBOUNCE_CYCLES+2).
- up_press/down_press: registered, high exactly one cycle, on the edge after the debounced level goes 0->1. No pulse on release.
- FSM states and transitions (evaluated on debounced levels):
  - NEUTRAL -> UP if up_db & !down_db.
  - NEUTRAL -> DOWN if down_db & !up_db.
  - UP -> NEUTRAL if !up_db or down_db.
  - DOWN -> NEUTRAL if !down_db or up_db.
  - Both pressed: NEUTRAL (base build).
  - UP <-> DOWN never direct in base build; always via NEUTRAL.
- Outputs: control_up = !(state==UP), control_down = !(state==DOWN), decoded from the state register only (glitch-free). Never both 0.
- Reset mid-debounce or mid-press: all progress discarded. After release, a still-held button needs a full DEBOUNCE_CYCLES window again.

Optional Feature:
- Macro LAST_PRESS_PRIORITY_EN.
- Defined: when both debounced levels are 1, the most recently pressed direction wins.
  - UP + down press edge -> DOWN directly; DOWN + up press edge -> UP directly.
  - NEUTRAL with both pressing on the same edge -> stays NEUTRAL.
  - Releasing the newer button while the older is still held returns to the older direction on the next edge.
- Undefined: both pressed -> NEUTRAL, as above.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset held 0, toggle buttons -> control_up=control_down=1, up_db=down_db=0, no press pulses. Assert reset mid-count -> cnt cleared; next press needs a full 4 stable cycles.
- btn_up_n 1->0 clean, sampled at E0 -> up_db=1 after E5, up_press high only during cycle after E5+1, control_up=0 after E6. control_down stays 1.
- btn_down_n bounces 0,1,0,1 each cycle, then stays 0 -> no change during bounce. down_db=1 only after 4+1 edges from the last bounce sample.
- Hold up (control_up=0), then press down -> base build: both controls 1 one edge after down_db=1. With LAST_PRESS_PRIORITY_EN: control_up=1 and control_down=0 on that same edge.
- With LAST_PRESS_PRIORITY_EN, release down while up held -> control_down=1 and control_up=0 one edge after down_db falls.
- Release up after a long hold -> up_db=0 after E0+5, control_up=1 after E0+6, no up_press pulse.
